// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RV32I-subset Fibonacci core: sequences fetch/decode/exec/mem/wb,
// resolves branches from ALU flags, counts retirements and traps on illegal words or handshake timeouts.
//
// state  | meaning
// IDLE   | held in reset, moves to FETCH next cycle
// FETCH  | imem_req until imem_valid, IR loaded on the handshake
// DECODE | legality check of IR
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data access until dmem_ready; sw retires here
// WB     | register write and PC update, retire
// TRAP   | sticky error, only rst leaves
module multicycle_control_unit #(
   parameter int TIMEOUT  = 16,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         instr,
   input  logic                imem_valid,
   input  logic                dmem_ready,
   input  logic                alu_zero,
   input  logic                alu_lt,
   input  logic                alu_ltu,
   output logic                imem_req,
   output logic                ir_load,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                regwrite,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                alusrc_a,
   output logic                alusrc_b,
   output logic [3:0]          alucontrol,
   output logic [2:0]          immsel,
   output logic [1:0]          wbsel,
   output logic                trap,
   output logic                retired,
   output logic [RETIRE_W-1:0] retire_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [2:0]        state;
   logic [2:0]        next_state;
   logic [31:0]       ir;
   logic [WAIT_W-1:0] wait_cnt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_ir;
   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7    = ir[31:25];
   assign unused_ir = ^{ir[24:15], ir[11:7]};

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
   logic legal, taken, timeout_hit;
   logic [3:0] alu_fn;

   always_comb begin
      is_r      = (opcode == OP_R);
      is_i      = (opcode == OP_I);
      is_load   = (opcode == OP_LOAD);
      is_store  = (opcode == OP_STORE);
      is_branch = (opcode == OP_BRANCH);
      is_jal    = (opcode == OP_JAL);
      is_jalr   = (opcode == OP_JALR);
      is_lui    = (opcode == OP_LUI);
      legal     = 1'b0;
      if (is_r)
         legal = ((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011}))
              || ((funct7 == 7'b0100000) && (funct3 == 3'b000));
      else if (is_i)
         legal = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
      else if (is_load || is_store)
         legal = (funct3 == 3'b010);
      else if (is_branch)
         legal = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
      else if (is_jalr)
         legal = (funct3 == 3'b000);
      else if (is_jal || is_lui)
         legal = 1'b1;
   end

   always_comb begin
      case (funct3)
         3'b111:  alu_fn = ALU_AND;
         3'b110:  alu_fn = ALU_OR;
         3'b100:  alu_fn = ALU_XOR;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         default: alu_fn = ALU_ADD;
      endcase
   end

   // Unsigned compares never reach EXEC (rejected in DECODE) but share the flag mux.
   always_comb begin
      case (funct3)
         3'b000:  taken = alu_zero;
         3'b001:  taken = !alu_zero;
         3'b100:  taken = alu_lt;
         3'b101:  taken = !alu_lt;
         3'b110:  taken = alu_ltu;
         3'b111:  taken = !alu_ltu;
         default: taken = 1'b0;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH:
            if (imem_valid)       next_state = S_DECODE;
            else if (timeout_hit) next_state = S_TRAP;
         S_DECODE: next_state = legal ? S_EXEC : S_TRAP;
         S_EXEC:
            if (is_branch)                 next_state = S_FETCH;
            else if (is_load || is_store)  next_state = S_MEM;
            else                           next_state = S_WB;
         S_MEM:
            if (dmem_ready)       next_state = is_load ? S_WB : S_FETCH;
            else if (timeout_hit) next_state = S_TRAP;
         S_WB:     next_state = S_FETCH;
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_IDLE;
      endcase
   end

   // Outputs are forced low while rst is high so aborted requests drop immediately.
   always_comb begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      regwrite   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alusrc_a   = 1'b0;
      alusrc_b   = 1'b0;
      alucontrol = ALU_ADD;
      immsel     = IMM_I;
      wbsel      = 2'b00;
      trap       = 1'b0;
      retired    = 1'b0;
      if (!rst) begin
         // Operand selection is held through MEM/WB so the address and result stay stable.
         if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            if (is_r) begin
               alucontrol = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : alu_fn;
            end else if (is_i) begin
               alucontrol = alu_fn;
               alusrc_b   = 1'b1;
            end else if (is_load || is_jalr) begin
               alusrc_b   = 1'b1;
            end else if (is_store) begin
               alusrc_b   = 1'b1;
               immsel     = IMM_S;
            end else if (is_branch) begin
               alucontrol = ALU_SUB;
               immsel     = IMM_B;
            end else if (is_jal) begin
               alusrc_a   = 1'b1;
               alusrc_b   = 1'b1;
               immsel     = IMM_J;
            end else if (is_lui) begin
               alucontrol = ALU_PASSB;
               alusrc_b   = 1'b1;
               immsel     = IMM_U;
            end
         end
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_load  = imem_valid;
            end
            S_EXEC:
               if (is_branch) begin
                  pc_write = 1'b1;
                  pc_src   = taken ? 2'b01 : 2'b00;
                  retired  = 1'b1;
               end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               if (dmem_ready && is_store) begin
                  pc_write = 1'b1;
                  retired  = 1'b1;
               end
            end
            S_WB: begin
               regwrite = 1'b1;
               pc_write = 1'b1;
               retired  = 1'b1;
               wbsel    = is_load ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
               pc_src   = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
            end
            S_TRAP: begin
               alucontrol = ALU_ADD;
               trap       = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ir         <= '0;
         wait_cnt   <= '0;
         retire_cnt <= '0;
      end else begin
         state <= next_state;
         if (ir_load)
            ir <= instr;
         if (next_state != state)
            wait_cnt <= '0;
         else if (state == S_FETCH || state == S_MEM)
            wait_cnt <= wait_cnt + 1'b1;
         if (retired)
            retire_cnt <= retire_cnt + RETIRE_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction cycle walks, waits, timeout trap,
// illegal-opcode trap and retire counter wrap (second instance with a 2-bit counter).
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        imem_valid, dmem_ready, alu_zero, alu_lt, alu_ltu;

   logic        imem_req, ir_load, dmem_req, dmem_we, regwrite, pc_write;
   logic [1:0]  pc_src, wbsel;
   logic        alusrc_a, alusrc_b, trap, retired;
   logic [3:0]  alucontrol;
   logic [2:0]  immsel;
   logic [31:0] retire_cnt;

   logic        s_imem_req, s_ir_load, s_dmem_req, s_dmem_we, s_regwrite, s_pc_write;
   logic [1:0]  s_pc_src, s_wbsel;
   logic        s_alusrc_a, s_alusrc_b, s_trap, s_retired;
   logic [3:0]  s_alucontrol;
   logic [2:0]  s_immsel;
   logic [1:0]  s_retire_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   logic [20:0] ctl;
   assign ctl = {imem_req, ir_load, dmem_req, dmem_we, regwrite, pc_write, pc_src,
                 alusrc_a, alusrc_b, alucontrol, immsel, wbsel, trap, retired};

   always #5 clk = ~clk;

   multicycle_control_unit #(.TIMEOUT(16), .RETIRE_W(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .regwrite(regwrite), .pc_write(pc_write), .pc_src(pc_src), .alusrc_a(alusrc_a),
      .alusrc_b(alusrc_b), .alucontrol(alucontrol), .immsel(immsel), .wbsel(wbsel),
      .trap(trap), .retired(retired), .retire_cnt(retire_cnt)
   );

   multicycle_control_unit #(.TIMEOUT(16), .RETIRE_W(2)) dut_small (
      .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .imem_req(s_imem_req), .ir_load(s_ir_load), .dmem_req(s_dmem_req), .dmem_we(s_dmem_we),
      .regwrite(s_regwrite), .pc_write(s_pc_write), .pc_src(s_pc_src), .alusrc_a(s_alusrc_a),
      .alusrc_b(s_alusrc_b), .alucontrol(s_alucontrol), .immsel(s_immsel), .wbsel(s_wbsel),
      .trap(s_trap), .retired(s_retired), .retire_cnt(s_retire_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One FETCH cycle with the handshake present; returns in DECODE.
   task automatic fetch(input logic [31:0] w);
      imem_valid = 1'b1;
      instr      = w;
      tick();
      imem_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      exp_cnt = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1; instr = '0; imem_valid = 0; dmem_ready = 0; alu_zero = 0; alu_lt = 0; alu_ltu = 0;
      tick(); tick();
      checks++; if (ctl !== 21'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", ctl); end
      checks++; if (retire_cnt !== 32'd0 || s_retire_cnt !== 2'd0) begin errors++;
         $display("FAIL reset_cnt got %0d/%0d want 0", retire_cnt, s_retire_cnt); end
      rst = 1'b0;
      #1;
      checks++; if (ctl !== 21'd0) begin errors++; $display("FAIL idle_outputs got %h want 0", ctl); end
      tick();
      checks++; if ({imem_req, ir_load, dmem_req, regwrite, pc_write} !== 5'b10000) begin errors++;
         $display("FAIL fetch_after_idle got %b want 10000", {imem_req, ir_load, dmem_req, regwrite, pc_write}); end
   endtask

   task automatic test_addi;
      imem_valid = 1'b1; instr = 32'h00500093;
      #1;
      checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL addi_ir_load got %b want 1", ir_load); end
      tick();
      imem_valid = 1'b0;
      checks++; if ({regwrite, pc_write, retired, imem_req} !== 4'b0000) begin errors++;
         $display("FAIL addi_decode got %b want 0000", {regwrite, pc_write, retired, imem_req}); end
      tick();
      checks++; if ({alucontrol, alusrc_a, alusrc_b, immsel, retired, regwrite} !== 11'b0000_0_1_000_0_0) begin
         errors++; $display("FAIL addi_exec got %b want 00000100000",
                            {alucontrol, alusrc_a, alusrc_b, immsel, retired, regwrite}); end
      tick();
      checks++; if ({regwrite, wbsel, pc_src, pc_write, retired} !== 7'b1_00_00_1_1) begin errors++;
         $display("FAIL addi_wb got %b want 1000011", {regwrite, wbsel, pc_src, pc_write, retired}); end
      exp_cnt++;
      tick();
      checks++; if (retire_cnt !== 32'(exp_cnt) || imem_req !== 1'b1) begin errors++;
         $display("FAIL addi_retire got cnt %0d req %b want cnt %0d req 1", retire_cnt, imem_req, exp_cnt); end
   endtask

   task automatic test_add_sub;
      logic [31:0] words [2];
      logic [3:0]  ops   [2];
      words[0] = 32'h002081B3; ops[0] = 4'b0000;
      words[1] = 32'h402081B3; ops[1] = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         fetch(words[i]);
         tick();
         checks++; if ({alucontrol, alusrc_b} !== {ops[i], 1'b0}) begin errors++;
            $display("FAIL rtype_exec[%0d] got %b want %b", i, {alucontrol, alusrc_b}, {ops[i], 1'b0}); end
         tick();
         checks++; if ({regwrite, retired, wbsel} !== 4'b1100) begin errors++;
            $display("FAIL rtype_wb[%0d] got %b want 1100", i, {regwrite, retired, wbsel}); end
         exp_cnt++;
         tick();
      end
      checks++; if (retire_cnt !== 32'(exp_cnt)) begin errors++;
         $display("FAIL rtype_cnt got %0d want %0d", retire_cnt, exp_cnt); end
   endtask

   task automatic test_branch;
      logic [31:0] words [4];
      logic        zs [4];
      logic        ls [4];
      logic [1:0]  srcs [4];
      words[0] = 32'h00209463; zs[0] = 0; ls[0] = 0; srcs[0] = 2'b01;
      words[1] = 32'h00209463; zs[1] = 1; ls[1] = 0; srcs[1] = 2'b00;
      words[2] = 32'h0020D463; zs[2] = 0; ls[2] = 1; srcs[2] = 2'b00;
      words[3] = 32'h00208463; zs[3] = 1; ls[3] = 1; srcs[3] = 2'b01;
      for (int i = 0; i < 4; i++) begin
         fetch(words[i]);
         tick();
         alu_zero = zs[i]; alu_lt = ls[i];
         #1;
         checks++; if ({pc_write, pc_src, regwrite, retired, alucontrol} !== {1'b1, srcs[i], 1'b0, 1'b1, 4'b0001}) begin
            errors++; $display("FAIL branch_exec[%0d] got %b want %b", i,
               {pc_write, pc_src, regwrite, retired, alucontrol}, {1'b1, srcs[i], 1'b0, 1'b1, 4'b0001}); end
         exp_cnt++;
         tick();
         alu_zero = 0; alu_lt = 0;
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL branch_cpi[%0d] got req %b want 1", i, imem_req); end
      end
   endtask

   task automatic test_lw;
      fetch(32'h0000A183);
      tick();
      checks++; if ({alucontrol, alusrc_b, immsel} !== 8'b0000_1_000) begin errors++;
         $display("FAIL lw_exec got %b want 00001000", {alucontrol, alusrc_b, immsel}); end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if ({dmem_req, dmem_we, retired} !== 3'b100) begin errors++;
            $display("FAIL lw_wait[%0d] got %b want 100", i, {dmem_req, dmem_we, retired}); end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      checks++; if ({dmem_req, dmem_we, regwrite, retired} !== 4'b1000) begin errors++;
         $display("FAIL lw_ready got %b want 1000", {dmem_req, dmem_we, regwrite, retired}); end
      tick();
      dmem_ready = 1'b0;
      checks++; if ({regwrite, wbsel, pc_src, retired, dmem_req} !== 7'b1_01_00_1_0) begin errors++;
         $display("FAIL lw_wb got %b want 1010010", {regwrite, wbsel, pc_src, retired, dmem_req}); end
      exp_cnt++;
      tick();
      checks++; if (imem_req !== 1'b1 || retire_cnt !== 32'(exp_cnt)) begin errors++;
         $display("FAIL lw_done got req %b cnt %0d want req 1 cnt %0d", imem_req, retire_cnt, exp_cnt); end
   endtask

   task automatic test_sw_jumps;
      fetch(32'h0020A223);
      tick();
      checks++; if ({alucontrol, alusrc_b, immsel} !== 8'b0000_1_001) begin errors++;
         $display("FAIL sw_exec got %b want 00001001", {alucontrol, alusrc_b, immsel}); end
      tick();
      dmem_ready = 1'b1;
      #1;
      checks++; if ({dmem_req, dmem_we, pc_write, pc_src, retired, regwrite} !== 7'b1_1_1_00_1_0) begin errors++;
         $display("FAIL sw_mem got %b want 1110010", {dmem_req, dmem_we, pc_write, pc_src, retired, regwrite}); end
      exp_cnt++;
      tick();
      dmem_ready = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sw_cpi got req %b want 1", imem_req); end
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if ({imem_req, ir_load} !== 2'b10) begin errors++;
            $display("FAIL fetch_wait[%0d] got %b want 10", i, {imem_req, ir_load}); end
         tick();
      end
      fetch(32'h008000EF);
      tick();
      checks++; if ({immsel, alusrc_a} !== 4'b100_1) begin errors++;
         $display("FAIL jal_exec got %b want 1001", {immsel, alusrc_a}); end
      tick();
      checks++; if ({regwrite, wbsel, pc_src, pc_write, retired} !== 7'b1_10_01_1_1) begin errors++;
         $display("FAIL jal_wb got %b want 1100111", {regwrite, wbsel, pc_src, pc_write, retired}); end
      exp_cnt++;
      tick();
      fetch(32'h00008067);
      tick(); tick();
      checks++; if ({regwrite, wbsel, pc_src, pc_write, retired} !== 7'b1_10_10_1_1) begin errors++;
         $display("FAIL jalr_wb got %b want 1101011", {regwrite, wbsel, pc_src, pc_write, retired}); end
      exp_cnt++;
      tick();
      fetch(32'h123450B7);
      tick();
      checks++; if ({alucontrol, alusrc_b, immsel} !== 8'b0111_1_011) begin errors++;
         $display("FAIL lui_exec got %b want 01111011", {alucontrol, alusrc_b, immsel}); end
      tick();
      checks++; if ({regwrite, wbsel, pc_src} !== 5'b1_00_00) begin errors++;
         $display("FAIL lui_wb got %b want 10000", {regwrite, wbsel, pc_src}); end
      exp_cnt++;
      tick();
      checks++; if (retire_cnt !== 32'(exp_cnt)) begin errors++;
         $display("FAIL jumps_cnt got %0d want %0d", retire_cnt, exp_cnt); end
   endtask

   task automatic test_illegal;
      fetch(32'hFFFFFFFF);
      checks++; if (retired !== 1'b0) begin errors++; $display("FAIL illegal_decode got retired %b want 0", retired); end
      tick();
      checks++; if (ctl !== 21'b10) begin errors++; $display("FAIL illegal_trap got %h want 2", ctl); end
      tick(); tick();
      checks++; if (trap !== 1'b1 || retire_cnt !== 32'(exp_cnt)) begin errors++;
         $display("FAIL illegal_hold got trap %b cnt %0d want trap 1 cnt %0d", trap, retire_cnt, exp_cnt); end
      do_reset();
   endtask

   task automatic test_timeout;
      fetch(32'h0000A183);
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         checks++; if ({dmem_req, trap} !== 2'b10) begin errors++;
            $display("FAIL timeout_wait[%0d] got %b want 10", i, {dmem_req, trap}); end
         tick();
      end
      checks++; if (ctl !== 21'b10) begin errors++; $display("FAIL timeout_trap got %h want 2", ctl); end
      imem_valid = 1'b1; dmem_ready = 1'b1;
      tick(); tick();
      checks++; if (ctl !== 21'b10) begin errors++; $display("FAIL timeout_sticky got %h want 2", ctl); end
      imem_valid = 1'b0; dmem_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (ctl !== 21'd0) begin errors++; $display("FAIL trap_rst got %h want 0", ctl); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (ctl !== 21'd0) begin errors++; $display("FAIL trap_idle got %h want 0", ctl); end
      tick();
      exp_cnt = 0;
      checks++; if (imem_req !== 1'b1 || trap !== 1'b0) begin errors++;
         $display("FAIL trap_exit got req %b trap %b want 1 0", imem_req, trap); end
   endtask

   task automatic test_abort;
      fetch(32'h0000A183);
      tick(); tick();
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL abort_mem got %b want 1", dmem_req); end
      rst = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL abort_drop got %b want 0", dmem_req); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (ctl !== 21'd0) begin errors++; $display("FAIL abort_idle got %h want 0", ctl); end
      tick();
      exp_cnt = 0;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         fetch(32'h00500093);
         tick(); tick(); tick();
         exp_cnt++;
         if (i == 2) begin
            checks++; if (s_retire_cnt !== 2'd3) begin errors++;
               $display("FAIL wrap_pre got %0d want 3", s_retire_cnt); end
         end
      end
      checks++; if (s_retire_cnt !== 2'd0 || retire_cnt !== 32'(exp_cnt)) begin errors++;
         $display("FAIL wrap got small %0d main %0d want 0 %0d", s_retire_cnt, retire_cnt, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_add_sub();
      test_branch();
      test_lw();
      test_sw_jumps();
      test_illegal();
      test_timeout();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle, parametrised control unit for the RV32I-subset Fibonacci core. It replaces the single-cycle combinational decoder with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memory, resolves branches from ALU flags, counts retired instructions, and traps on illegal opcodes or memory timeouts. It sits between the instruction register/memories and the datapath (register file, ALU, immediate generator, PC mux).

## Interface
- TIMEOUT, 16: max cycles waiting on imem_valid or dmem_ready before trapping; 0 disables the timeout.
- RETIRE_W, 32: width of the retired-instruction counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  instruction word, sampled when imem_valid is high in FETCH.
- imem_valid  input  1  instruction memory has data.
- dmem_ready  input  1  data access complete.
- alu_zero, alu_lt, alu_ltu  input  1 each  flags from ALU SUB result: equal, signed less-than, unsigned less-than.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instr into the instruction register.
- dmem_req, dmem_we  output  1 each  data request; write enable.
- regwrite, pc_write  output  1 each  register-file write; PC update.
- pc_src  output  2  00 PC+4, 01 PC+imm, 10 {alu_out[31:1],0}.
- alusrc_a  output  1  0 rs1, 1 PC.
- alusrc_b  output  1  0 rs2, 1 imm.
- alucontrol  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 PASSB.
- immsel  output  3  000 I, 001 S, 010 B, 011 U, 100 J.
- wbsel  output  2  00 ALU, 01 MEM, 10 PC+4.
- trap  output  1  sticky error flag.
- retired  output  1  one-cycle pulse per completed instruction.
- retire_cnt  output  RETIRE_W  retired-instruction count; wraps to 0.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. IDLE is held during rst and goes to FETCH on the next cycle.
- Supported instructions:
  - R: add, sub, and, or, xor, slt, sltu. funct7 is 0000000, or 0100000 for sub only.
  - I: addi, andi, ori, xori, slti, lw (funct3 010).
  - S: sw (010).
  - B: beq, bne, blt, bge.
  - jal, jalr (funct3 000), lui.
- Any other opcode/funct3/funct7 combination is illegal.
- FETCH: imem_req=1 until imem_valid. In the imem_valid cycle, ir_load=1 and the next state is DECODE.
- DECODE: illegal goes to TRAP, otherwise to EXEC. Register-file read happens in the datapath; there are no writes.
- EXEC: alucontrol, alusrc_a/b and immsel are driven per instruction.
  - R/I ALU ops, lui (PASSB, U) and jalr (ADD rs1+imm, I): go to WB.
  - lw/sw: ADD rs1+imm (I or S imm), go to MEM.
  - Branch: SUB rs1-rs2. pc_write=1 with pc_src=01 if taken, else 00. retired=1, then FETCH.
  - Taken rules: beq=alu_zero, bne=!alu_zero, blt=alu_lt, bge=!alu_lt.
  - jal: go to WB.
- MEM: dmem_req=1 (dmem_we=1 for sw) until dmem_ready.
  - lw on ready: go to WB.
  - sw on ready: pc_write=1 with pc_src=00, retired=1, then FETCH.
- WB: regwrite=1 and pc_write=1, then FETCH.
  - wbsel: MEM for lw, PC+4 for jal/jalr, ALU otherwise.
  - pc_src: 01 for jal, 10 for jalr, 00 otherwise.
  - retired=1.
- Writes to x0 are the register file's concern; the control unit does not suppress them.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each waiting cycle. When it reaches TIMEOUT without a handshake, go to TRAP. If the handshake arrives in the same cycle the count is reached, the handshake wins.
- TRAP: all control outputs 0 and trap=1. Only rst leaves TRAP.
- retire_cnt increments on each retired pulse and wraps modulo 2^RETIRE_W.

## Timing
- Reset: state IDLE; every output 0 including trap and retire_cnt; wait counter 0.
- rst asserted in any state (including mid-MEM) returns to IDLE on the next edge. Aborted requests drop in that same cycle.
- All control outputs are decoded combinationally from state plus the registered IR. Counters and state are registered.
- Minimum cycles per instruction:
  - Branch: 3 (FETCH, DECODE, EXEC).
  - ALU/lui/jal/jalr: 4.
  - sw: 4.
  - lw: 5.
  - Each wait cycle on imem/dmem adds 1.
- A handshake seen in its first request cycle adds no latency.

## Test plan
- addi x1,x0,5 (0x00500093), imem_valid on the first FETCH cycle: EXEC shows ADD, alusrc_b=1, immsel=000. WB shows regwrite=1, wbsel=00, pc_src=00. retired is pulsed in cycle 4 and retire_cnt=1.
- add 0x002081B3 then sub 0x402081B3: alucontrol is 0000 then 0001, alusrc_b=0, and retire_cnt reaches 2 after 8 cycles.
- bne (funct3 001, opcode 1100011):
  - alu_zero=0: pc_write=1, pc_src=01.
  - alu_zero=1: pc_src=00.
  - In both cases regwrite=0 and there are 3 cycles per instruction.
- lw with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0, then WB with wbsel=01. 8 total cycles.
- dmem_ready never asserted with TIMEOUT=16: TRAP entered after 16 MEM cycles, trap=1, all outputs 0, held until rst. rst then gives IDLE, then FETCH.
- Illegal word 0xFFFFFFFF: TRAP right after DECODE, retired never pulses, retire_cnt unchanged. With RETIRE_W=2, 4 retirements wrap retire_cnt to 0.
